// File: rtl/msrv32_ir_skid_buffer.sv
// Instruction-register stage: a two-entry skid buffer (main + skid) that decodes the
// opcode into the immediate-type code as each word is captured.
module msrv32_ir_skid_buffer #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  output logic        instr_ready_out,
  input  logic        flush_in,
  output logic [24:0] instr_out,
  output logic [6:0]  opcode_out,
  output logic [2:0]  imm_type_out,
  output logic        illegal_opcode_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [1:0]  count_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

  // The decode travels with the word so the outputs come straight from flops.
  function automatic entry_t decode(input logic [31:0] instr);
    entry_t e;
    e.instr    = instr;
    e.illegal  = 1'b0;
    e.imm_type = 3'b111;
    case (instr[6:0])
      7'b0110011:                                     e.imm_type = 3'b000;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: e.imm_type = 3'b001;
      7'b0100011:                                     e.imm_type = 3'b010;
      7'b1100011:                                     e.imm_type = 3'b011;
      7'b0110111, 7'b0010111:                         e.imm_type = 3'b100;
      7'b1101111:                                     e.imm_type = 3'b101;
      7'b1110011:                                     e.imm_type = 3'b110;
      default: begin
        e.imm_type = 3'b111;
        e.illegal  = 1'b1;
      end
    endcase
    return e;
  endfunction

  state_t state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   push, pop;
  logic   load_main, load_skid, main_from_skid;

  assign push     = instr_valid_in & instr_ready_out;
  assign pop      = valid_out & ready_in;
  assign in_entry = decode(instr_in);

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_in) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (push && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d        = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the data registers are
  // reset too because the reset NOP must be visible on the outputs.
  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q         <= EMPTY;
      main_q          <= decode(RESET_INSTR);
      skid_q          <= '0;
      instr_ready_out <= 1'b1;
    end else begin
      state_q         <= state_d;
      instr_ready_out <= (state_d != FULL);
      if (load_main) begin
        main_q <= in_entry;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign valid_out          = (state_q != EMPTY);
  assign count_out          = state_q;
  assign instr_out          = main_q.instr[31:7];
  assign opcode_out         = main_q.instr[6:0];
  assign imm_type_out       = main_q.imm_type;
  assign illegal_opcode_out = main_q.illegal;

endmodule
